// File: rtl/unified_mem_arbiter_if.sv
// Bundle of the fetch requester, data requester and memory-port signals seen by
// the unified memory arbiter; master is the arbiter side, slave the core/memory side.
interface unified_mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;

    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;

    logic        stall_if;
    logic        stall_mem;

    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        input  if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ready, dm_rdata, dm_ready, stall_if, stall_mem,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport slave (
        output if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ready, dm_rdata, dm_ready, stall_if, stall_mem,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and the data stage,
// alternating after every data access so fetch can never starve.
module unified_mem_arbiter #(
    parameter int unsigned LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    unified_mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_CNT = 4'(LATENCY);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        gnt_q, gnt_d;
    logic        fetch_next_q, fetch_next_d;
    logic        cmd_we_q, cmd_we_d;
    logic [3:0]  cmd_be_q, cmd_be_d;
    logic [31:0] cmd_addr_q, cmd_addr_d;
    logic [31:0] cmd_wdata_q, cmd_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            gnt_q        <= 1'b0;
            fetch_next_q <= 1'b0;
            cmd_we_q     <= 1'b0;
            cmd_be_q     <= 4'd0;
            cmd_addr_q   <= 32'd0;
            cmd_wdata_q  <= 32'd0;
            if_rdata_q   <= 32'd0;
            dm_rdata_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gnt_q        <= gnt_d;
            fetch_next_q <= fetch_next_d;
            cmd_we_q     <= cmd_we_d;
            cmd_be_q     <= cmd_be_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        gnt_d        = gnt_q;
        fetch_next_d = fetch_next_q;
        cmd_we_d     = cmd_we_q;
        cmd_be_d     = cmd_be_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        case (state_q)
            IDLE: begin
                // Data normally wins; the turn passes to fetch right after a data access.
                if (bus.if_req && (fetch_next_q || !bus.dm_req)) begin
                    gnt_d       = 1'b0;
                    cmd_we_d    = 1'b0;
                    cmd_be_d    = 4'hF;
                    cmd_addr_d  = bus.if_addr;
                    cmd_wdata_d = 32'd0;
                    cnt_d       = LAT_CNT;
                    state_d     = BUSY;
                end else if (bus.dm_req) begin
                    gnt_d       = 1'b1;
                    cmd_we_d    = bus.dm_we;
                    cmd_be_d    = bus.dm_we ? bus.dm_be : 4'hF;
                    cmd_addr_d  = bus.dm_addr;
                    cmd_wdata_d = bus.dm_wdata;
                    cnt_d       = LAT_CNT;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    if (!gnt_q) begin
                        if_rdata_d = bus.mem_rdata;
                    end else if (!cmd_we_q) begin
                        dm_rdata_d = bus.mem_rdata;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                fetch_next_d = gnt_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_en    = (state_q == BUSY);
    assign bus.mem_we    = cmd_we_q;
    assign bus.mem_be    = cmd_be_q;
    assign bus.mem_addr  = cmd_addr_q;
    assign bus.mem_wdata = cmd_wdata_q;

    assign bus.if_ready  = (state_q == RESP) && !gnt_q;
    assign bus.dm_ready  = (state_q == RESP) && gnt_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;

    assign bus.stall_if  = bus.if_req & ~bus.if_ready;
    assign bus.stall_mem = bus.dm_req & ~bus.dm_ready;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed reset/abort run at LATENCY=4, then a scripted
// plus randomized run at LATENCY=2 scored against a cycle-timeline transaction model.
module tb_unified_mem_arbiter;
    localparam int L2   = 2;
    localparam int L4   = 4;
    localparam int NCYC = 400;

    logic clk = 1'b0;
    logic reset2;
    logic reset4;
    int   total = 0;
    int   bad   = 0;

    unified_mem_arbiter_if bus2 ();
    unified_mem_arbiter_if bus4 ();

    unified_mem_arbiter #(.LATENCY(L2)) u_dut2 (.clk(clk), .reset(reset2), .bus(bus2));
    unified_mem_arbiter #(.LATENCY(L4)) u_dut4 (.clk(clk), .reset(reset4), .bus(bus4));

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hE3A0_1005;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Memory models: valid data only in the LATENCY-th consecutive mem_en cycle.
    int en_cnt2;
    int en_cnt4;
    always @(posedge clk or posedge reset2)
        if (reset2) en_cnt2 <= 0;
        else        en_cnt2 <= bus2.mem_en ? en_cnt2 + 1 : 0;
    always @(posedge clk or posedge reset4)
        if (reset4) en_cnt4 <= 0;
        else        en_cnt4 <= bus4.mem_en ? en_cnt4 + 1 : 0;
    always_comb bus2.mem_rdata = (bus2.mem_en && en_cnt2 == L2 - 1) ? mem_f(bus2.mem_addr) : 32'h0BAD_F00D;
    always_comb bus4.mem_rdata = (bus4.mem_en && en_cnt4 == L4 - 1) ? mem_f(bus4.mem_addr) : 32'h0BAD_F00D;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Transaction model state for the LATENCY=2 instance
    int          free_at;
    bit          last_data;
    bit          txn_act;
    bit          txn_data;
    int          txn_grant;
    logic [31:0] txn_addr;
    logic [31:0] txn_wdata;
    logic        txn_we;
    logic [3:0]  txn_be;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_dm_rdata;
    bit          if_owed;
    bit          dm_owed;

    initial begin
        bit exp_en;
        bit exp_rdy;
        bit take_if;
        bit start;

        reset2 = 1'b1;
        reset4 = 1'b1;
        bus2.if_req = 1'b1; bus2.if_addr = 32'd0;
        bus2.dm_req = 1'b0; bus2.dm_we = 1'b0; bus2.dm_be = 4'd0;
        bus2.dm_addr = 32'd0; bus2.dm_wdata = 32'd0;
        bus4.if_req = 1'b0; bus4.if_addr = 32'd0;
        bus4.dm_req = 1'b0; bus4.dm_we = 1'b0; bus4.dm_be = 4'd0;
        bus4.dm_addr = 32'd0; bus4.dm_wdata = 32'd0;
        #2;
        check_val("rst_stall_if",  32'(bus2.stall_if),  32'd1);
        check_val("rst_stall_mem", 32'(bus2.stall_mem), 32'd0);
        check_val("rst_mem_en",    32'(bus2.mem_en),    32'd0);
        check_val("rst_mem_we",    32'(bus2.mem_we),    32'd0);
        check_val("rst_mem_be",    32'(bus2.mem_be),    32'd0);
        check_val("rst_mem_addr",  bus2.mem_addr,       32'd0);
        check_val("rst_mem_wdata", bus2.mem_wdata,      32'd0);
        check_val("rst_if_ready",  32'(bus2.if_ready),  32'd0);
        check_val("rst_dm_ready",  32'(bus2.dm_ready),  32'd0);
        check_val("rst_if_rdata",  bus2.if_rdata,       32'd0);
        check_val("rst_dm_rdata",  bus2.dm_rdata,       32'd0);
        bus2.if_req = 1'b0;

        // LATENCY=4: read aborted by reset in its second BUSY cycle, then a fresh read.
        @(negedge clk); reset4 = 1'b0;
        @(negedge clk);
        bus4.dm_req = 1'b1; bus4.dm_we = 1'b0; bus4.dm_addr = 32'h80;
        @(negedge clk);
        check_val("l4_busy_en", 32'(bus4.mem_en), 32'd1);
        @(negedge clk);
        reset4 = 1'b1;
        #1;
        check_val("l4_async_en",    32'(bus4.mem_en),    32'd0);
        check_val("l4_async_rdy",   32'(bus4.dm_ready),  32'd0);
        check_val("l4_async_stall", 32'(bus4.stall_mem), 32'd1);
        bus4.dm_addr = 32'hC4;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val("l4_rst_rdy", 32'(bus4.dm_ready), 32'd0);
            check_val("l4_rst_en",  32'(bus4.mem_en),   32'd0);
        end
        reset4 = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check_val("l4_en",  32'(bus4.mem_en),   32'((k >= 1) && (k <= L4)));
            check_val("l4_rdy", 32'(bus4.dm_ready), 32'(k == L4 + 1));
            if (k >= 1 && k <= L4) check_val("l4_addr", bus4.mem_addr, 32'hC4);
            check_val("l4_rdata", bus4.dm_rdata, (k >= L4 + 1) ? mem_f(32'hC4) : 32'd0);
            if (k == L4 + 1) begin
                $display("txn l4 data read addr=%h rdata=%h", 32'hC4, bus4.dm_rdata);
                bus4.dm_req = 1'b0;
            end
        end

        // LATENCY=2: scripted fetch, store, contention, saturation, then random traffic.
        free_at = 0; last_data = 1'b0; txn_act = 1'b0; txn_data = 1'b0; txn_grant = 0;
        txn_addr = '0; txn_wdata = '0; txn_we = 1'b0; txn_be = '0;
        exp_if_rdata = '0; exp_dm_rdata = '0; if_owed = 1'b0; dm_owed = 1'b0;
        @(negedge clk); reset2 = 1'b0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            exp_en  = txn_act && (cyc > txn_grant) && (cyc <= txn_grant + L2);
            exp_rdy = txn_act && (cyc == txn_grant + L2 + 1);
            if (exp_rdy && !txn_we) begin
                if (txn_data) exp_dm_rdata = mem_f(txn_addr);
                else          exp_if_rdata = mem_f(txn_addr);
            end
            check_val("mem_en",    32'(bus2.mem_en),    32'(exp_en));
            check_val("if_ready",  32'(bus2.if_ready),  32'(exp_rdy && !txn_data));
            check_val("dm_ready",  32'(bus2.dm_ready),  32'(exp_rdy && txn_data));
            check_val("stall_if",  32'(bus2.stall_if),  32'(bus2.if_req && !(exp_rdy && !txn_data)));
            check_val("stall_mem", 32'(bus2.stall_mem), 32'(bus2.dm_req && !(exp_rdy && txn_data)));
            if (exp_en) begin
                check_val("mem_addr", bus2.mem_addr,     txn_addr);
                check_val("mem_we",   32'(bus2.mem_we),  32'(txn_we));
                check_val("mem_be",   32'(bus2.mem_be),  32'(txn_be));
                if (txn_we) check_val("mem_wdata", bus2.mem_wdata, txn_wdata);
            end
            check_val("if_rdata", bus2.if_rdata, exp_if_rdata);
            check_val("dm_rdata", bus2.dm_rdata, exp_dm_rdata);
            if (exp_rdy) begin
                $display("txn cyc=%0d %s addr=%h we=%0d be=%h if_rdata=%h dm_rdata=%h",
                         cyc, txn_data ? "data " : "fetch", txn_addr, txn_we, txn_be,
                         bus2.if_rdata, bus2.dm_rdata);
                if (txn_data) dm_owed = 1'b0; else if_owed = 1'b0;
                txn_act   = 1'b0;
                last_data = txn_data;
            end

            // Fetch requester
            if (!if_owed) begin
                start = (cyc == 0) || (cyc == 12) || (cyc >= 24 && cyc < 60) ||
                        (cyc >= 60 && $urandom_range(0, 3) == 0);
                if (start) begin
                    if_owed = 1'b1;
                    bus2.if_req = 1'b1;
                    bus2.if_addr = (cyc == 0) ? 32'h100 : (cyc == 12) ? 32'h200 : ($urandom & ~32'h3);
                end else begin
                    bus2.if_req = 1'b0;
                end
            end else if (cyc >= 60 && txn_act && !txn_data && cyc > txn_grant &&
                         $urandom_range(0, 7) == 0) begin
                bus2.if_req  = 1'b0;
                bus2.if_addr = $urandom;
            end

            // Data requester; a withdrawn request scrambles its inputs while it waits.
            if (!dm_owed) begin
                start = (cyc == 6) || (cyc == 12) || (cyc >= 24 && cyc < 60) ||
                        (cyc >= 60 && $urandom_range(0, 2) == 0);
                if (start) begin
                    dm_owed = 1'b1;
                    bus2.dm_req = 1'b1;
                    if (cyc == 6) begin
                        bus2.dm_we = 1'b1; bus2.dm_be = 4'b0011;
                        bus2.dm_addr = 32'h40; bus2.dm_wdata = 32'hDEAD_BEEF;
                    end else if (cyc < 60) begin
                        bus2.dm_we = 1'b0; bus2.dm_be = 4'($urandom);
                        bus2.dm_addr = (cyc == 12) ? 32'h44 : ($urandom & ~32'h3);
                        bus2.dm_wdata = $urandom;
                    end else begin
                        bus2.dm_we = 1'($urandom); bus2.dm_be = 4'($urandom);
                        bus2.dm_addr = $urandom & ~32'h3; bus2.dm_wdata = $urandom;
                    end
                end else begin
                    bus2.dm_req = 1'b0;
                end
            end else if (!bus2.dm_req) begin
                bus2.dm_we = 1'($urandom); bus2.dm_be = 4'($urandom);
                bus2.dm_addr = $urandom; bus2.dm_wdata = $urandom;
            end else if (cyc >= 60 && txn_act && txn_data && cyc > txn_grant &&
                         $urandom_range(0, 5) == 0) begin
                bus2.dm_req = 1'b0;
            end

            // Model arbitration: the block samples requests only when idle.
            if (!txn_act && cyc >= free_at && (bus2.if_req || bus2.dm_req)) begin
                take_if   = bus2.if_req && (last_data || !bus2.dm_req);
                txn_act   = 1'b1;
                txn_data  = !take_if;
                txn_grant = cyc;
                free_at   = cyc + L2 + 2;
                txn_addr  = take_if ? bus2.if_addr : bus2.dm_addr;
                txn_we    = take_if ? 1'b0 : bus2.dm_we;
                txn_be    = (take_if || !bus2.dm_we) ? 4'hF : bus2.dm_be;
                txn_wdata = bus2.dm_wdata;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
